// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master with CS setup/hold and CS-held bursts
module spi_master_param #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic [WORD_WIDTH-1:0] i_tx_word,
    input  logic                  i_keep_cs,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [WORD_WIDTH-1:0] o_rx_word,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_cs_n,
    input  logic                  i_miso
);
    localparam int MAXC = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                               : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int EW   = $clog2(2 * WORD_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_WAIT_NEXT} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [EW-1:0]         r_edge;
    logic [WORD_WIDTH-1:0] r_tx;
    logic [WORD_WIDTH-1:0] r_rx;
    logic                  r_keep;
    logic                  r_hold_done;

    logic [WORD_WIDTH-1:0] w_tx_shifted;
    logic [WORD_WIDTH-1:0] w_rx_next;
    logic [WORD_WIDTH-1:0] w_rx_final;
    logic                  w_toggle;
    logic                  w_leading;
    logic                  w_last;
    logic                  w_capture;
    logic                  w_accept;

    function automatic logic first_bit(input logic [WORD_WIDTH-1:0] w);
        return MSB_FIRST ? w[WORD_WIDTH-1] : w[0];
    endfunction

    assign w_tx_shifted = MSB_FIRST ? {r_tx[WORD_WIDTH-2:0], 1'b0} : {1'b0, r_tx[WORD_WIDTH-1:1]};
    assign w_rx_next    = MSB_FIRST ? {r_rx[WORD_WIDTH-2:0], i_miso} : {i_miso, r_rx[WORD_WIDTH-1:1]};
    assign w_toggle     = (r_cnt == CW'(CLK_DIV - 1));
    // r_edge counts SCLK toggles within the word; even indices are leading edges
    assign w_leading    = ~r_edge[0];
    assign w_last       = (r_edge == EW'(2 * WORD_WIDTH - 1));
    assign w_capture    = CPHA ? ~w_leading : w_leading;
    assign w_rx_final   = w_capture ? w_rx_next : r_rx;
    assign w_accept     = i_start & i_enable & ((r_state == S_IDLE) | (r_state == S_WAIT_NEXT));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_edge      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_keep      <= 1'b0;
            r_hold_done <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rx_word   <= '0;
            o_sclk      <= CPOL;
            o_mosi      <= 1'b0;
            o_cs_n      <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SETUP;
                        o_cs_n  <= 1'b0;
                        o_busy  <= 1'b1;
                        r_tx    <= i_tx_word;
                        o_mosi  <= first_bit(i_tx_word);
                        r_keep  <= i_keep_cs;
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_rx    <= '0;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CW'(CS_SETUP - 1)) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_toggle) begin
                        r_cnt  <= '0;
                        o_sclk <= ~o_sclk;
                        if (!w_last)
                            r_edge <= r_edge + 1'b1;
                        if (w_capture)
                            r_rx <= w_rx_next;
                        if (!CPHA && !w_leading && !w_last) begin
                            r_tx   <= w_tx_shifted;
                            o_mosi <= first_bit(w_tx_shifted);
                        end
                        if (CPHA && w_leading) begin
                            r_tx   <= w_tx_shifted;
                            o_mosi <= first_bit(r_tx);
                        end
                        if (w_last) begin
                            if (r_keep) begin
                                r_state   <= S_WAIT_NEXT;
                                o_done    <= 1'b1;
                                o_busy    <= 1'b0;
                                o_rx_word <= w_rx_final;
                            end else begin
                                r_state     <= S_HOLD;
                                r_hold_done <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CW'(CS_HOLD - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        o_cs_n  <= 1'b1;
                        o_busy  <= 1'b0;
                        o_done  <= r_hold_done;
                        if (r_hold_done)
                            o_rx_word <= r_rx;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_NEXT: begin
                    // a burst continues straight into SHIFT; CS is already set up
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                        o_busy  <= 1'b1;
                        r_tx    <= i_tx_word;
                        o_mosi  <= first_bit(i_tx_word);
                        r_keep  <= i_keep_cs;
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_rx    <= '0;
                    end else if (!i_enable) begin
                        r_state     <= S_HOLD;
                        o_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_hold_done <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - scoreboard bench for spi_master_param (three parameter sets)
module tb_spi_master_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        en0 = 1'b1, start0 = 1'b0, keep0 = 1'b0;
    logic [15:0] tx0 = '0;
    logic        busy0, done0, sclk0, mosi0, cs0, miso0;
    logic [15:0] rx0;

    logic        en1 = 1'b1, start1 = 1'b0, keep1 = 1'b0;
    logic [15:0] tx1 = '0;
    logic        busy1, done1, sclk1, mosi1, cs1;
    logic        miso1 = 1'b0;
    logic [15:0] rx1;

    logic        en2 = 1'b1, start2 = 1'b0, keep2 = 1'b0;
    logic [7:0]  tx2 = '0;
    logic        busy2, done2, sclk2, mosi2, cs2, miso2;
    logic [7:0]  rx2;

    assign miso0 = mosi0;
    assign miso2 = mosi2;

    spi_master_param u0 (
        .i_clock(clk), .i_reset(rst), .i_enable(en0), .i_start(start0), .i_tx_word(tx0),
        .i_keep_cs(keep0), .o_busy(busy0), .o_done(done0), .o_rx_word(rx0), .o_sclk(sclk0),
        .o_mosi(mosi0), .o_cs_n(cs0), .i_miso(miso0));

    spi_master_param #(.CPOL(1'b1), .CPHA(1'b1)) u1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en1), .i_start(start1), .i_tx_word(tx1),
        .i_keep_cs(keep1), .o_busy(busy1), .o_done(done1), .o_rx_word(rx1), .o_sclk(sclk1),
        .o_mosi(mosi1), .o_cs_n(cs1), .i_miso(miso1));

    spi_master_param #(.WORD_WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) u2 (
        .i_clock(clk), .i_reset(rst), .i_enable(en2), .i_start(start2), .i_tx_word(tx2),
        .i_keep_cs(keep2), .o_busy(busy2), .o_done(done2), .o_rx_word(rx2), .o_sclk(sclk2),
        .o_mosi(mosi2), .o_cs_n(cs2), .i_miso(miso2));

    // Mode-3 slave for u1: drives the next bit on each leading (falling) SCLK edge
    logic [15:0] pat1 = 16'hA5C3;
    int          idx1 = 15;
    always @(negedge sclk1) begin
        if (idx1 >= 0) begin
            miso1 = pat1[idx1];
            idx1  = idx1 - 1;
        end
    end

    int rises0 = 0;
    int lows0  = 0;
    always @(posedge sclk0) rises0 = rises0 + 1;
    always @(negedge clk) if (cs0 === 1'b0) lows0 = lows0 + 1;

    typedef struct { logic [31:0] rx; int cyc; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb(input int d, input logic [31:0] act);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL dut%0d_unexpected_done: got done at cycle %0d expected none", d, cyc);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("dut%0d_rx_word", d), act, e.rx);
            check($sformatf("dut%0d_done_cycle", d), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done0) sb(0, {16'h0, rx0});
            if (done1) sb(1, {16'h0, rx1});
            if (done2) sb(2, {24'h0, rx2});
        end
    end

    task automatic go(input int d, input logic [15:0] tx, input logic keep);
        case (d)
            0:       begin start0 = 1'b1; tx0 = tx; keep0 = keep; end
            1:       begin start1 = 1'b1; tx1 = tx; keep1 = keep; end
            default: begin start2 = 1'b1; tx2 = tx[7:0]; keep2 = keep; end
        endcase
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        keep0 = 1'b0; keep1 = 1'b0; keep2 = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done0(input string nm);
        int k;
        k = 0;
        while (done0 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(nm, done0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, r0, l0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs0, 1'b1);
        check("rst_sclk_cpol0", sclk0, 1'b0);
        check("rst_sclk_cpol1", sclk1, 1'b1);
        check("rst_mosi", mosi0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_rx_word", rx0, 16'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: default mode, loopback
        r0 = rises0; l0 = lows0; n = cyc;
        q0.push_back('{32'hF800, n + 133});
        go(0, 16'hF800, 1'b0);
        check("t1_cs_low_c1", cs0, 1'b0);
        check("t1_busy_c1", busy0, 1'b1);
        check("t1_mosi_first", mosi0, 1'b1);
        wait_until(n + 132);
        check("t1_cs_low_c132", cs0, 1'b0);
        wait_until(n + 133);
        check("t1_cs_high_c133", cs0, 1'b1);
        wait_until(n + 136);
        check("t1_rises", rises0 - r0, 16);
        check("t1_cs_low_cycles", lows0 - l0, 132);

        // 2: CPOL=1 CPHA=1 with slave pattern
        n = cyc;
        q1.push_back('{32'hA5C3, n + 133});
        go(1, 16'h0000, 1'b0);
        wait_until(n + 137);
        check("t2_sclk_idle_high", sclk1, 1'b1);
        check("t2_cs_idle", cs1, 1'b1);

        // 6: 8-bit, CLK_DIV=1, LSB first
        n = cyc;
        q2.push_back('{32'h01, n + 21});
        go(2, 16'h0001, 1'b0);
        check("t6_mosi_first_lsb", mosi2, 1'b1);
        wait_until(n + 24);

        // 3: two-word burst with CS held
        r0 = rises0; l0 = lows0; n = cyc;
        q0.push_back('{32'h1234, n + 131});
        go(0, 16'h1234, 1'b1);
        wait_done0("t3_first_done_timeout");
        m = cyc;
        check("t3_cs_low_wait_next", cs0, 1'b0);
        check("t3_busy_wait_next", busy0, 1'b0);
        q0.push_back('{32'h5678, m + 131});
        go(0, 16'h5678, 1'b0);
        check("t3_busy_second", busy0, 1'b1);
        wait_until(m + 135);
        check("t3_rises", rises0 - r0, 32);
        check("t3_cs_low_cycles", lows0 - l0, 261);

        // WAIT_NEXT with enable dropped ends the burst without another done
        n = cyc;
        q0.push_back('{32'h0F0F, n + 131});
        go(0, 16'h0F0F, 1'b1);
        wait_done0("tw_done_timeout");
        m = cyc;
        en0 = 1'b0;
        wait_until(m + 1);
        check("tw_busy_hold", busy0, 1'b1);
        wait_until(m + 2);
        check("tw_cs_low_hold", cs0, 1'b0);
        wait_until(m + 3);
        check("tw_cs_released", cs0, 1'b1);
        check("tw_busy_idle", busy0, 1'b0);
        en0 = 1'b1;
        repeat (3) @(negedge clk);

        // 4: ignored starts (disabled in IDLE, and while busy)
        en0 = 1'b0;
        l0 = lows0;
        go(0, 16'hAAAA, 1'b0);
        repeat (10) @(negedge clk);
        check("t4_disabled_no_cs", lows0 - l0, 0);
        check("t4_disabled_not_busy", busy0, 1'b0);
        en0 = 1'b1;
        r0 = rises0; n = cyc;
        q0.push_back('{32'h3C3C, n + 133});
        go(0, 16'h3C3C, 1'b0);
        wait_until(n + 30);
        go(0, 16'hFFFF, 1'b0);
        wait_until(n + 150);
        check("t4_single_word_rises", rises0 - r0, 16);
        check("t4_idle_after", busy0, 1'b0);

        // 5: asynchronous reset mid-SHIFT
        n = cyc;
        go(0, 16'h5555, 1'b0);
        wait_until(n + 40);
        check("t5_sclk_high_before", sclk0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5_cs_n_async", cs0, 1'b1);
        check("t5_sclk_async", sclk0, 1'b0);
        check("t5_busy_async", busy0, 1'b0);
        check("t5_mosi_async", mosi0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n = cyc;
        q0.push_back('{32'h00FF, n + 133});
        go(0, 16'h00FF, 1'b0);
        wait_until(n + 140);

        check("pending_q0", q0.size(), 0);
        check("pending_q1", q1.size(), 0);
        check("pending_q2", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
